mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  M-stage data-memory access unit; consumes memenM/memWriteM from the main decoder pipeline.
//  Builds size/strobes/aligned write data and drives an SRAM-like req/addr_ok/data_ok bus.
//  Stalls the pipeline until the access completes, then extracts and extends load data for W.
//  Raises address-error exceptions for misaligned accesses (optional).
// PARAMETERS
//  ADDR_W  32  data bus address width
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-low reset
//  memenM        in   1       M-stage instruction is a load/store
//  memWriteM     in   1       1=store, 0=load
//  mem_op_M      in   3       000 B, 001 BU, 010 H, 011 HU, 100 W; 101-111 treated as W
//  addr_M        in   ADDR_W  effective address
//  wdata_M       in   32      store data (rt)
//  flushM        in   1       exception flush of M stage
//  stall_other   in   1       pipeline held by another source
//  data_req      out  1       bus request
//  data_wr       out  1       bus write
//  data_size     out  2       0 byte, 1 half, 2 word
//  data_addr     out  ADDR_W  bus address
//  data_wdata    out  32      replicated store data
//  data_wstrb    out  4       byte strobes (0 for loads)
//  data_addr_ok  in   1       request accepted
//  data_data_ok  in   1       data returned / write done
//  data_rdata    in   32      raw read word
//  stall_mem     out  1       hold F..M stages
//  rdata_M       out  32      extended load result
//  adel_M        out  1       load address error
//  ades_M        out  1       store address error
//  badvaddr_M    out  ADDR_W  faulting address
// BEHAVIOUR
//  Reset: state IDLE, cancel=0, all outputs 0; async, valid mid-transaction (req dropped at once).
//  go = memenM & ~flushM & ~adel_M & ~ades_M.
//  IDLE: data_req=go, bus fields from M inputs; stall_mem=go. addr_ok -> WAIT, else go -> REQ
//    (latch wr/size/addr/wdata/wstrb/op/addr[1:0]).
//  REQ: data_req=1 from latched regs (stable until addr_ok); stall_mem=1; addr_ok -> WAIT.
//  WAIT: data_req=0; stall_mem=1; data_ok -> DONE (rdata_M<=extracted value), or IDLE if cancel.
//  DONE: stall_mem=0, rdata_M held; ~stall_other -> IDLE, else stay (no new request).
//  Min load latency: req cycle + data_ok cycle, stall released the cycle after data_ok.
//  Loads and stores both wait for data_ok.
//  flushM in REQ/WAIT: request not withdrawn; set cancel, drain to data_ok, discard data, rdata_M
//    unchanged; while draining stall_mem = memenM & ~flushM. cancel clears on return to IDLE.
//  Strobes: B 4'b0001<<addr[1:0]; H addr[1]?4'b1100:4'b0011; W 4'b1111.
//  wdata: B {4{wdata_M[7:0]}}; H {2{wdata_M[15:0]}}; W as-is.
//  Load extract: byte/half selected by addr[1:0]/addr[1]; B/H sign-extend, BU/HU zero-extend.
// CONFIGURATION
//  MEM_ADDR_CHECK_EN defined: H with addr[0]!=0, W with addr[1:0]!=0 -> adel_M (load) or ades_M
//    (store) =1 combinationally, badvaddr_M=addr_M, no request, stall_mem=0.
//  Undefined: adel_M=ades_M=0, badvaddr_M=0; data_addr low bits forced 0 for H (bit0) and
//    W (bits1:0); access proceeds.
// TESTING
//  LB addr 0x1003, rdata 0x80FF1234 -> rdata_M 0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x1002 wdata 0x0000ABCD -> wstrb 1100, data_wdata 0xABCDABCD, size 1, wr 1.
//  LW, addr_ok after 3 cycles, data_ok 2 later -> req/addr stable 4 cycles, stall_mem 6 cycles.
//  flushM during WAIT -> no rdata_M update, IDLE on data_ok; next LW req only after data_ok.
//  LW addr 0x1001: with macro adel_M=1, badvaddr 0x1001, no req; without, req addr 0x1000.
//  DONE with stall_other=1 for 3 cycles -> rdata_M stable, no req; rst low in WAIT -> req 0, IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access unit: drives an SRAM-like req/addr_ok/data_ok bus and extends load data.
// Define MEM_ADDR_CHECK_EN to raise address-error exceptions for misaligned half/word accesses.
module mem_access_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memenM,
   input  logic              memWriteM,
   input  logic [2:0]        mem_op_M,
   input  logic [ADDR_W-1:0] addr_M,
   input  logic [31:0]       wdata_M,
   input  logic              flushM,
   input  logic              stall_other,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [31:0]       data_wdata,
   output logic [3:0]        data_wstrb,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata,
   output logic              stall_mem,
   output logic [31:0]       rdata_M,
   output logic              adel_M,
   output logic              ades_M,
   output logic [ADDR_W-1:0] badvaddr_M
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state;
   logic              cancel;
   logic              lat_wr;
   logic [1:0]        lat_size;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic [3:0]        lat_wstrb;
   logic [2:0]        lat_op;
   logic [1:0]        lat_lo;

   logic [1:0]        cur_size;
   logic [3:0]        cur_strb;
   logic [31:0]       cur_wdata;
   logic [ADDR_W-1:0] cur_addr;
   logic              go;
   logic              draining;
   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;
   logic [31:0]       load_data;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cur_size  = mem_op_M[2] ? 2'd2 : {1'b0, mem_op_M[1]};
      cur_strb  = 4'b1111;
      cur_wdata = wdata_M;
      case (cur_size)
         2'd0: begin
            cur_strb  = 4'b0001 << addr_M[1:0];
            cur_wdata = {4{wdata_M[7:0]}};
         end
         2'd1: begin
            cur_strb  = addr_M[1] ? 4'b1100 : 4'b0011;
            cur_wdata = {2{wdata_M[15:0]}};
         end
         default: ;
      endcase
      if (!memWriteM) cur_strb = 4'b0000;
   end

`ifdef MEM_ADDR_CHECK_EN
   logic misaligned;
   assign misaligned = (cur_size == 2'd1) ? addr_M[0]
                     : (cur_size == 2'd2) ? |addr_M[1:0] : 1'b0;
   assign adel_M     = memenM & misaligned & ~memWriteM;
   assign ades_M     = memenM & misaligned & memWriteM;
   assign badvaddr_M = (adel_M | ades_M) ? addr_M : '0;
   assign cur_addr   = addr_M;
`else
   assign adel_M     = 1'b0;
   assign ades_M     = 1'b0;
   assign badvaddr_M = '0;
   // Without the check, misaligned halves/words are silently rounded down to their natural boundary.
   always_comb begin
      cur_addr = addr_M;
      if (cur_size == 2'd1)      cur_addr[0]   = 1'b0;
      else if (cur_size == 2'd2) cur_addr[1:0] = 2'b00;
   end
`endif

   assign go       = memenM & ~flushM & ~adel_M & ~ades_M;
   assign draining = cancel | flushM;

   always_comb begin
      data_req   = 1'b0;
      data_wr    = 1'b0;
      data_size  = 2'd0;
      data_addr  = '0;
      data_wdata = '0;
      data_wstrb = 4'b0000;
      stall_mem  = 1'b0;
      case (state)
         IDLE: begin
            data_req  = go;
            stall_mem = go;
            if (go) begin
               data_wr    = memWriteM;
               data_size  = cur_size;
               data_addr  = cur_addr;
               data_wdata = cur_wdata;
               data_wstrb = cur_strb;
            end
         end
         REQ: begin
            data_req   = 1'b1;
            data_wr    = lat_wr;
            data_size  = lat_size;
            data_addr  = lat_addr;
            data_wdata = lat_wdata;
            data_wstrb = lat_wstrb;
            stall_mem  = draining ? (memenM & ~flushM) : 1'b1;
         end
         WAIT:    stall_mem = draining ? (memenM & ~flushM) : 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      sel_byte = data_rdata[{lat_lo, 3'b000} +: 8];
      sel_half = lat_lo[1] ? data_rdata[31:16] : data_rdata[15:0];
      case (lat_op)
         3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_data = {24'h0, sel_byte};
         3'b010:  load_data = {{16{sel_half[15]}}, sel_half};
         3'b011:  load_data = {16'h0, sel_half};
         default: load_data = data_rdata;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cancel    <= 1'b0;
         lat_wr    <= 1'b0;
         lat_size  <= 2'd0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= 4'b0000;
         lat_op    <= 3'd0;
         lat_lo    <= 2'd0;
         rdata_M   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  lat_wr    <= memWriteM;
                  lat_size  <= cur_size;
                  lat_addr  <= cur_addr;
                  lat_wdata <= cur_wdata;
                  lat_wstrb <= cur_strb;
                  lat_op    <= mem_op_M;
                  lat_lo    <= addr_M[1:0];
                  state     <= data_addr_ok ? WAIT : REQ;
               end
            end
            REQ: begin
               if (flushM)       cancel <= 1'b1;
               if (data_addr_ok) state  <= WAIT;
            end
            WAIT: begin
               if (flushM) cancel <= 1'b1;
               if (data_data_ok) begin
                  // A flushed access still drains its data_ok, but the result is thrown away.
                  if (draining) begin
                     state  <= IDLE;
                     cancel <= 1'b0;
                  end else begin
                     state   <= DONE;
                     rdata_M <= load_data;
                  end
               end
            end
            DONE: if (!stall_other) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
